// File: rtl/alu4_op_scheduler_if.sv
// Bundle of requester handshakes, response channels and shared 4-bit unit
// connections used by alu4_op_scheduler. slave = scheduler side.
interface alu4_op_scheduler_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [7:0] rsp0_result;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp1_result;
  logic [1:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_result;
  logic       busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output alu_op, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  alu_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu4_op_scheduler.sv
// Two-requester scheduler for the shared combinational 4-bit ALU, one op in flight.
// Define ALU4_SCHED_RR_EN for round-robin tie breaking; otherwise req0 has fixed priority.
module alu4_op_scheduler #(
  parameter int UNIT_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu4_op_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // UNIT_LAT must be 1..15; it loads a 4-bit down counter.
  localparam logic [3:0] LAT = 4'(UNIT_LAT);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       owner;
  logic       grant_any;
  logic       grant_sel;
  logic       accept;
  logic [1:0] alu_op_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [7:0] rsp0_result_q;
  logic [7:0] rsp1_result_q;

  assign grant_any = bus.req0_valid | bus.req1_valid;
  assign accept    = (state == IDLE) && grant_any;

`ifdef ALU4_SCHED_RR_EN
  // ptr holds the last granted requester; resetting it to 1 hands the first tie to req0.
  logic ptr;

  always_comb begin
    grant_sel = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant_sel = ~ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b1;
    else if (accept)
      ptr <= grant_sel;
  end
`else
  always_comb begin
    grant_sel = ~bus.req0_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_any) state_next = EXEC;
      EXEC: if (cnt == 4'd1) state_next = RESP;
      RESP: if (owner ? bus.rsp1_ready : bus.rsp0_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched only on a grant so the unit inputs never toggle otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 4'd0;
      owner         <= 1'b0;
      alu_op_q      <= 2'b00;
      alu_a_q       <= 4'h0;
      alu_b_q       <= 4'h0;
      rsp0_result_q <= 8'h00;
      rsp1_result_q <= 8'h00;
    end else if (accept) begin
      owner    <= grant_sel;
      cnt      <= LAT;
      alu_op_q <= grant_sel ? bus.req1_op : bus.req0_op;
      alu_a_q  <= grant_sel ? bus.req1_a  : bus.req0_a;
      alu_b_q  <= grant_sel ? bus.req1_b  : bus.req0_b;
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (owner)
          rsp1_result_q <= bus.alu_result;
        else
          rsp0_result_q <= bus.alu_result;
      end
    end
  end

  always_comb begin
    bus.req0_ready  = accept && !grant_sel;
    bus.req1_ready  = accept && grant_sel;
    bus.rsp0_valid  = (state == RESP) && !owner;
    bus.rsp1_valid  = (state == RESP) && owner;
    bus.rsp0_result = rsp0_result_q;
    bus.rsp1_result = rsp1_result_q;
    bus.alu_op      = alu_op_q;
    bus.alu_a       = alu_a_q;
    bus.alu_b       = alu_b_q;
    bus.busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_alu4_op_scheduler.sv
// Directed bench for alu4_op_scheduler: one DUT with UNIT_LAT=1, one with UNIT_LAT=3.
// Arbitration expectations follow ALU4_SCHED_RR_EN.
module tb_alu4_op_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu4_op_scheduler_if if1 ();
  alu4_op_scheduler_if if3 ();

  alu4_op_scheduler #(.UNIT_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  alu4_op_scheduler #(.UNIT_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] unit_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return {3'b000, ({1'b0, a} + {1'b0, b})};
      2'b01:   return {4'h0, a} - {4'h0, b};
      2'b10:   return {4'h0, a} * {4'h0, b};
      default: return {6'b0, (a > b), (a == b)};
    endcase
  endfunction

  assign if1.alu_result = unit_model(if1.alu_op, if1.alu_a, if1.alu_b);
  assign if3.alu_result = unit_model(if3.alu_op, if3.alu_a, if3.alu_b);

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic sel, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    if (sel) begin
      if1.req1_valid = 1'b1; if1.req1_op = op; if1.req1_a = a; if1.req1_b = b;
    end else begin
      if1.req0_valid = 1'b1; if1.req0_op = op; if1.req0_a = a; if1.req0_b = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until either ready is seen on if1, bounded to 20 cycles.
  task automatic wait_grant1(input string tag, output logic g);
    int cyc = 0;
    #1;
    while (!(if1.req0_ready || if1.req1_ready) && cyc < 20) begin
      tick();
      cyc++;
    end
    check_output(tag, 32'(cyc < 20), 32'd1);
    g = if1.req1_ready;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       g;
  logic       seen;
  logic [1:0] exp_grant [3];
  logic [7:0] exp_res;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if1.req0_valid = 0; if1.req0_op = 0; if1.req0_a = 0; if1.req0_b = 0;
    if1.req1_valid = 0; if1.req1_op = 0; if1.req1_a = 0; if1.req1_b = 0;
    if1.rsp0_ready = 0; if1.rsp1_ready = 0;
    if3.req0_valid = 0; if3.req0_op = 0; if3.req0_a = 0; if3.req0_b = 0;
    if3.req1_valid = 0; if3.req1_op = 0; if3.req1_a = 0; if3.req1_b = 0;
    if3.rsp0_ready = 0; if3.rsp1_ready = 0;

    #12;
    check_output("rst_busy",    32'(if1.busy), 32'd0);
    check_output("rst_rsp0v",   32'(if1.rsp0_valid), 32'd0);
    check_output("rst_rsp1v",   32'(if1.rsp1_valid), 32'd0);
    check_output("rst_rsp0r",   32'(if1.rsp0_result), 32'h00);
    check_output("rst_alu",     32'({if1.alu_op, if1.alu_a, if1.alu_b}), 32'h0);
    check_output("rst_readies", 32'({if1.req0_ready, if1.req1_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: single add with UNIT_LAT=1
    $display("[TB] scenario 1: add 9+7");
    tick();
    if1.rsp0_ready = 1'b1;
    apply_stimulus(1'b0, 2'b00, 4'h9, 4'h7);
    #1;
    check_output("s1_req0_ready", 32'(if1.req0_ready), 32'd1);
    check_output("s1_req1_ready", 32'(if1.req1_ready), 32'd0);
    tick();
    if1.req0_valid = 1'b0;
    check_output("s1_t0_alu",  32'({if1.alu_a, if1.alu_b}), 32'h97);
    check_output("s1_t0_busy", 32'(if1.busy), 32'd1);
    check_output("s1_t0_rspv", 32'(if1.rsp0_valid), 32'd0);
    tick();
    check_output("s1_t1_rsp0v", 32'(if1.rsp0_valid), 32'd1);
    check_output("s1_t1_res",   32'(if1.rsp0_result), 32'h10);
    check_output("s1_t1_rsp1v", 32'(if1.rsp1_valid), 32'd0);
    check_output("s1_t1_busy",  32'(if1.busy), 32'd1);
    tick();
    check_output("s1_t2_rsp0v", 32'(if1.rsp0_valid), 32'd0);
    check_output("s1_t2_busy",  32'(if1.busy), 32'd0);
    check_output("s1_t2_hold",  32'({if1.alu_op, if1.alu_a, if1.alu_b}), 32'h097);

    // Scenario 2: both requesters held valid, arbitration order
    $display("[TB] scenario 2: contention");
    pulse_reset();
`ifdef ALU4_SCHED_RR_EN
    exp_grant[0] = 2'd0; exp_grant[1] = 2'd1; exp_grant[2] = 2'd0;
`else
    exp_grant[0] = 2'd0; exp_grant[1] = 2'd0; exp_grant[2] = 2'd0;
`endif
    tick();
    if1.rsp0_ready = 1'b1;
    if1.rsp1_ready = 1'b1;
    apply_stimulus(1'b0, 2'b10, 4'hF, 4'hF);
    apply_stimulus(1'b1, 2'b01, 4'h3, 4'h5);
    for (int k = 0; k < 3; k++) begin
      wait_grant1("s2_wait", g);
      check_output("s2_grant", 32'(g), 32'(exp_grant[k]));
      exp_res = exp_grant[k][0] ? 8'hFE : 8'hE1;
      tick();
      tick();
      if (exp_grant[k][0]) begin
        check_output("s2_rsp1v",  32'(if1.rsp1_valid), 32'd1);
        check_output("s2_rsp1r",  32'(if1.rsp1_result), 32'(exp_res));
        check_output("s2_other0", 32'(if1.rsp0_valid), 32'd0);
      end else begin
        check_output("s2_rsp0v",  32'(if1.rsp0_valid), 32'd1);
        check_output("s2_rsp0r",  32'(if1.rsp0_result), 32'(exp_res));
        check_output("s2_other1", 32'(if1.rsp1_valid), 32'd0);
      end
      tick();
    end
    if1.req0_valid = 1'b0;
    if1.req1_valid = 1'b0;
    tick();
    tick();

    // Scenario 3: response backpressure
    $display("[TB] scenario 3: backpressure");
    if1.rsp0_ready = 1'b0;
    apply_stimulus(1'b0, 2'b00, 4'h3, 4'h4);
    wait_grant1("s3_wait", g);
    check_output("s3_grant", 32'(g), 32'd0);
    tick();
    if1.req0_valid = 1'b0;
    apply_stimulus(1'b1, 2'b00, 4'h1, 4'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output("s3_rsp0v",   32'(if1.rsp0_valid), 32'd1);
      check_output("s3_res",     32'(if1.rsp0_result), 32'h07);
      check_output("s3_readies", 32'({if1.req0_ready, if1.req1_ready}), 32'd0);
      check_output("s3_busy",    32'(if1.busy), 32'd1);
      tick();
    end
    if1.rsp0_ready = 1'b1;
    if1.req1_valid = 1'b0;
    tick();
    check_output("s3_done_v",    32'(if1.rsp0_valid), 32'd0);
    check_output("s3_done_busy", 32'(if1.busy), 32'd0);

    // Scenario 4: reset in the middle of EXEC
    $display("[TB] scenario 4: reset mid-EXEC");
    if1.rsp1_ready = 1'b1;
    apply_stimulus(1'b1, 2'b11, 4'h5, 4'h5);
    wait_grant1("s4_wait", g);
    check_output("s4_grant", 32'(g), 32'd1);
    tick();
    if1.req1_valid = 1'b0;
    check_output("s4_busy_pre", 32'(if1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("s4_rst_busy",  32'(if1.busy), 32'd0);
    check_output("s4_rst_alu",   32'({if1.alu_op, if1.alu_a, if1.alu_b}), 32'h0);
    check_output("s4_rst_rsp1",  32'({if1.rsp1_valid, if1.rsp1_result}), 32'h0);
    check_output("s4_rst_rsp0r", 32'(if1.rsp0_result), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | if1.rsp1_valid;
    end
    check_output("s4_no_rsp", 32'(seen), 32'd0);
    apply_stimulus(1'b1, 2'b11, 4'h5, 4'h5);
    wait_grant1("s4_wait2", g);
    check_output("s4_regrant", 32'(g), 32'd1);
    tick();
    if1.req1_valid = 1'b0;
    tick();
    check_output("s4_rsp1v", 32'(if1.rsp1_valid), 32'd1);
    check_output("s4_rsp1r", 32'(if1.rsp1_result), 32'h01);
    tick();

    // Scenario 5: UNIT_LAT=3 compare, then back-to-back issue interval
    $display("[TB] scenario 5: UNIT_LAT=3");
    if3.rsp1_ready = 1'b1;
    if3.req1_valid = 1'b1; if3.req1_op = 2'b11; if3.req1_a = 4'hA; if3.req1_b = 4'h2;
    #1;
    check_output("s5_ready", 32'(if3.req1_ready), 32'd1);
    tick();
    check_output("s5_t0_busy", 32'(if3.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_output("s5_alu",    32'({if3.alu_op, if3.alu_a, if3.alu_b}), 32'h3A2);
      check_output("s5_rspv",   32'(if3.rsp1_valid), 32'd0);
      check_output("s5_nready", 32'(if3.req1_ready), 32'd0);
      tick();
    end
    check_output("s5_t3_rspv",   32'(if3.rsp1_valid), 32'd1);
    check_output("s5_t3_res",    32'(if3.rsp1_result), 32'h02);
    check_output("s5_t3_nready", 32'(if3.req1_ready), 32'd0);
    tick();
    check_output("s5_t4_rspv",  32'(if3.rsp1_valid), 32'd0);
    check_output("s5_t4_busy",  32'(if3.busy), 32'd0);
    check_output("s5_t4_ready", 32'(if3.req1_ready), 32'd1);
    tick();
    if3.req1_valid = 1'b0;
    check_output("s5_t5_busy", 32'(if3.busy), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check_output("s5_end_busy", 32'(if3.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
